// File: rtl/i2c_reg_access.sv
`default_nettype none
// ============================================================================
// Module      : i2c_reg_access
// Description : Turns one register read/write request into i2c_master command
//               and data streams and returns a single response.
//               Optional abort timer: define I2C_REG_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_reg_access #(
    parameter int REG_ADDR_BYTES = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  req_dev_addr,
    input  logic [15:0] req_reg_addr,
    input  logic [7:0]  req_wdata,
    input  logic        req_read,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_nack,
    output logic        rsp_timeout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [6:0]  m_axis_cmd_address,
    output logic        m_axis_cmd_start,
    output logic        m_axis_cmd_read,
    output logic        m_axis_cmd_write,
    output logic        m_axis_cmd_write_multiple,
    output logic        m_axis_cmd_stop,
    output logic        m_axis_cmd_valid,
    input  logic        m_axis_cmd_ready,
    output logic [7:0]  m_axis_data_tdata,
    output logic        m_axis_data_tvalid,
    input  logic        m_axis_data_tready,
    output logic        m_axis_data_tlast,
    input  logic [7:0]  s_axis_data_tdata,
    input  logic        s_axis_data_tvalid,
    output logic        s_axis_data_tready,
    input  logic        missed_ack,
    output logic        busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CMD_W    = 3'd1;
    localparam logic [2:0] S_DATA_REG = 3'd2;
    localparam logic [2:0] S_DATA_VAL = 3'd3;
    localparam logic [2:0] S_CMD_R    = 3'd4;
    localparam logic [2:0] S_WAIT_RD  = 3'd5;
    localparam logic [2:0] S_RESP     = 3'd6;

    localparam logic c_last_idx = 1'(REG_ADDR_BYTES - 1);

    logic [2:0]  r_state, w_state;
    logic [6:0]  r_dev, w_dev;
    logic [15:0] r_reg, w_reg;
    logic [7:0]  r_wdata, w_wdata;
    logic        r_read, w_read;
    logic        r_idx, w_idx;

    logic        w_req_ready, w_rsp_nack, w_rsp_timeout, w_rsp_valid;
    logic [7:0]  w_rsp_rdata, w_tdata, w_reg_byte;
    logic        w_cmd_start, w_cmd_read, w_cmd_wm, w_cmd_stop, w_cmd_valid;
    logic        w_tvalid, w_tlast, w_s_tready, w_busy;
    logic        w_expired;

    assign m_axis_cmd_address = r_dev;
    assign m_axis_cmd_write   = 1'b0;
    // Register address goes out MSB first; the last index always carries the low byte.
    assign w_reg_byte = (r_idx == c_last_idx) ? r_reg[7:0] : r_reg[15:8];

`ifdef I2C_REG_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic        w_wait_state, w_hs;

    assign w_wait_state = (r_state == S_CMD_W) || (r_state == S_DATA_REG) ||
                          (r_state == S_DATA_VAL) || (r_state == S_CMD_R) ||
                          (r_state == S_WAIT_RD);
    assign w_hs = (m_axis_cmd_valid && m_axis_cmd_ready) ||
                  (m_axis_data_tvalid && m_axis_data_tready) ||
                  (s_axis_data_tready && s_axis_data_tvalid);
    assign w_expired = w_wait_state && !w_hs && (r_tmo_cnt == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE || w_hs) begin
            r_tmo_cnt <= '0;
        end else if (w_wait_state) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
    assign w_expired = 1'b0;
`endif

    always_comb begin
        w_state       = r_state;
        w_dev         = r_dev;
        w_reg         = r_reg;
        w_wdata       = r_wdata;
        w_read        = r_read;
        w_idx         = r_idx;
        w_req_ready   = req_ready;
        w_rsp_rdata   = rsp_rdata;
        w_rsp_nack    = rsp_nack;
        w_rsp_timeout = rsp_timeout;
        w_rsp_valid   = rsp_valid;
        w_cmd_start   = m_axis_cmd_start;
        w_cmd_read    = m_axis_cmd_read;
        w_cmd_wm      = m_axis_cmd_write_multiple;
        w_cmd_stop    = m_axis_cmd_stop;
        w_cmd_valid   = m_axis_cmd_valid;
        w_tdata       = m_axis_data_tdata;
        w_tvalid      = m_axis_data_tvalid;
        w_tlast       = m_axis_data_tlast;
        w_s_tready    = s_axis_data_tready;

        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid && req_ready) begin
                    w_dev         = req_dev_addr;
                    w_reg         = req_reg_addr;
                    w_wdata       = req_wdata;
                    w_read        = req_read;
                    w_idx         = 1'b0;
                    w_rsp_nack    = 1'b0;
                    w_rsp_timeout = 1'b0;
                    w_rsp_rdata   = 8'h00;
                    w_req_ready   = 1'b0;
                    w_state       = S_CMD_W;
                end
            end
            S_CMD_W: begin
                if (!m_axis_cmd_valid) begin
                    w_cmd_valid = 1'b1;
                    w_cmd_start = 1'b1;
                    w_cmd_read  = 1'b0;
                    w_cmd_wm    = 1'b1;
                    w_cmd_stop  = !r_read;
                end else if (m_axis_cmd_ready) begin
                    w_cmd_valid = 1'b0;
                    w_state     = S_DATA_REG;
                end
            end
            S_DATA_REG: begin
                if (!m_axis_data_tvalid) begin
                    w_tvalid = 1'b1;
                    w_tdata  = w_reg_byte;
                    w_tlast  = r_read && (r_idx == c_last_idx);
                end else if (m_axis_data_tready) begin
                    w_tvalid = 1'b0;
                    if (r_idx == c_last_idx) begin
                        w_state = r_read ? S_CMD_R : S_DATA_VAL;
                    end else begin
                        w_idx = 1'b1;
                    end
                end
            end
            S_DATA_VAL: begin
                if (!m_axis_data_tvalid) begin
                    w_tvalid = 1'b1;
                    w_tdata  = r_wdata;
                    w_tlast  = 1'b1;
                end else if (m_axis_data_tready) begin
                    w_tvalid    = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_state     = S_RESP;
                end
            end
            S_CMD_R: begin
                if (!m_axis_cmd_valid) begin
                    w_cmd_valid = 1'b1;
                    w_cmd_start = 1'b1;
                    w_cmd_read  = 1'b1;
                    w_cmd_wm    = 1'b0;
                    w_cmd_stop  = 1'b1;
                end else if (m_axis_cmd_ready) begin
                    w_cmd_valid = 1'b0;
                    w_state     = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (!s_axis_data_tready) begin
                    w_s_tready = 1'b1;
                end else if (s_axis_data_tvalid) begin
                    w_s_tready  = 1'b0;
                    w_rsp_rdata = s_axis_data_tdata;
                    w_rsp_valid = 1'b1;
                    w_state     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_req_ready = 1'b1;
                    w_state     = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // A presented response must not change, so late NACKs in RESP are ignored.
        if (missed_ack && r_state != S_IDLE && r_state != S_RESP) begin
            w_rsp_nack = 1'b1;
        end

        if (w_expired) begin
            w_cmd_valid   = 1'b0;
            w_tvalid      = 1'b0;
            w_s_tready    = 1'b0;
            w_rsp_timeout = 1'b1;
            w_rsp_rdata   = 8'h00;
            w_rsp_valid   = 1'b1;
            w_state       = S_RESP;
        end

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state                   <= S_IDLE;
            r_dev                     <= '0;
            r_reg                     <= '0;
            r_wdata                   <= '0;
            r_read                    <= 1'b0;
            r_idx                     <= 1'b0;
            req_ready                 <= 1'b0;
            rsp_rdata                 <= '0;
            rsp_nack                  <= 1'b0;
            rsp_timeout               <= 1'b0;
            rsp_valid                 <= 1'b0;
            m_axis_cmd_start          <= 1'b0;
            m_axis_cmd_read           <= 1'b0;
            m_axis_cmd_write_multiple <= 1'b0;
            m_axis_cmd_stop           <= 1'b0;
            m_axis_cmd_valid          <= 1'b0;
            m_axis_data_tdata         <= '0;
            m_axis_data_tvalid        <= 1'b0;
            m_axis_data_tlast         <= 1'b0;
            s_axis_data_tready        <= 1'b0;
            busy                      <= 1'b0;
        end else begin
            r_state                   <= w_state;
            r_dev                     <= w_dev;
            r_reg                     <= w_reg;
            r_wdata                   <= w_wdata;
            r_read                    <= w_read;
            r_idx                     <= w_idx;
            req_ready                 <= w_req_ready;
            rsp_rdata                 <= w_rsp_rdata;
            rsp_nack                  <= w_rsp_nack;
            rsp_timeout               <= w_rsp_timeout;
            rsp_valid                 <= w_rsp_valid;
            m_axis_cmd_start          <= w_cmd_start;
            m_axis_cmd_read           <= w_cmd_read;
            m_axis_cmd_write_multiple <= w_cmd_wm;
            m_axis_cmd_stop           <= w_cmd_stop;
            m_axis_cmd_valid          <= w_cmd_valid;
            m_axis_data_tdata         <= w_tdata;
            m_axis_data_tvalid        <= w_tvalid;
            m_axis_data_tlast         <= w_tlast;
            s_axis_data_tready        <= w_s_tready;
            busy                      <= w_busy;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_reg_access
// Description : Self-checking bench for i2c_reg_access with 1- and 2-byte
//               register addressing, random backpressure and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_reg_access;

    localparam int c_tmo = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          sel = 0;
    bit          bp = 1'b0;
    bit          hold_cmd = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [6:0]  req_dev_addr = '0;
    logic [15:0] req_reg_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_read = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b1;
    logic        cmd_ready = 1'b1;
    logic        mdata_tready = 1'b1;
    logic        s_tvalid = 1'b1;
    logic [7:0]  s_tdata = '0;
    logic        missed_ack = 1'b0;

    logic        d_req_ready [2];
    logic [7:0]  d_rsp_rdata [2];
    logic        d_rsp_nack [2];
    logic        d_rsp_tmo [2];
    logic        d_rsp_valid [2];
    logic [6:0]  d_cmd_addr [2];
    logic        d_cmd_start [2];
    logic        d_cmd_read [2];
    logic        d_cmd_write [2];
    logic        d_cmd_wm [2];
    logic        d_cmd_stop [2];
    logic        d_cmd_valid [2];
    logic [7:0]  d_tdata [2];
    logic        d_tvalid [2];
    logic        d_tlast [2];
    logic        d_s_tready [2];
    logic        d_busy [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        i2c_reg_access #(
            .REG_ADDR_BYTES(g + 1),
            .TIMEOUT_CYCLES(c_tmo)
        ) u_dut (
            .clk                       (clk),
            .rst                       (rst),
            .req_dev_addr              (req_dev_addr),
            .req_reg_addr              (req_reg_addr),
            .req_wdata                 (req_wdata),
            .req_read                  (req_read),
            .req_valid                 (req_valid && (sel == g)),
            .req_ready                 (d_req_ready[g]),
            .rsp_rdata                 (d_rsp_rdata[g]),
            .rsp_nack                  (d_rsp_nack[g]),
            .rsp_timeout               (d_rsp_tmo[g]),
            .rsp_valid                 (d_rsp_valid[g]),
            .rsp_ready                 (rsp_ready),
            .m_axis_cmd_address        (d_cmd_addr[g]),
            .m_axis_cmd_start          (d_cmd_start[g]),
            .m_axis_cmd_read           (d_cmd_read[g]),
            .m_axis_cmd_write          (d_cmd_write[g]),
            .m_axis_cmd_write_multiple (d_cmd_wm[g]),
            .m_axis_cmd_stop           (d_cmd_stop[g]),
            .m_axis_cmd_valid          (d_cmd_valid[g]),
            .m_axis_cmd_ready          (cmd_ready),
            .m_axis_data_tdata         (d_tdata[g]),
            .m_axis_data_tvalid        (d_tvalid[g]),
            .m_axis_data_tready        (mdata_tready),
            .m_axis_data_tlast         (d_tlast[g]),
            .s_axis_data_tdata         (s_tdata),
            .s_axis_data_tvalid        (s_tvalid && (sel == g)),
            .s_axis_data_tready        (d_s_tready[g]),
            .missed_ack                (missed_ack && (sel == g)),
            .busy                      (d_busy[g])
        );
    end

    // Views of whichever DUT is currently under test.
    logic        cur_req_ready, cur_cmd_valid, cur_tvalid, cur_rsp_valid, cur_s_tready, cur_tmo;
    logic [11:0] cur_cmd;
    logic [8:0]  cur_dat;
    logic [9:0]  cur_rsp;
    logic [13:0] out_a;
    logic [22:0] out_b;
    assign cur_req_ready = d_req_ready[sel];
    assign cur_cmd_valid = d_cmd_valid[sel];
    assign cur_tvalid    = d_tvalid[sel];
    assign cur_rsp_valid = d_rsp_valid[sel];
    assign cur_s_tready  = d_s_tready[sel];
    assign cur_tmo       = d_rsp_tmo[sel];
    assign cur_cmd = {d_cmd_addr[sel], d_cmd_start[sel], d_cmd_read[sel], d_cmd_write[sel],
                      d_cmd_wm[sel], d_cmd_stop[sel]};
    assign cur_dat = {d_tlast[sel], d_tdata[sel]};
    assign cur_rsp = {d_rsp_rdata[sel], d_rsp_nack[sel], d_rsp_tmo[sel]};
    assign out_a = {d_rsp_rdata[sel], d_rsp_nack[sel], d_rsp_tmo[sel], d_rsp_valid[sel],
                    d_req_ready[sel], d_busy[sel], d_s_tready[sel]};
    assign out_b = {cur_cmd, d_cmd_valid[sel], d_tdata[sel], d_tvalid[sel], d_tlast[sel]};

    logic [11:0] act_cmd[$];
    logic [8:0]  act_dat[$];
    logic [9:0]  act_rsp[$];
    int          s_hs = 0;
    int          acc_cyc = 0;
    int          rsp_cyc = 0;
    logic        rsp_cvalid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        cmd_ready    = !hold_cmd && (!bp || $urandom_range(0, 2) != 0);
        mdata_tready = !bp || $urandom_range(0, 2) != 0;
        rsp_ready    = !bp || $urandom_range(0, 2) != 0;
        s_tvalid     = !bp || $urandom_range(0, 2) != 0;
    end

    // Monitor: records handshakes and checks that stalled beats stay put.
    initial begin
        logic        p_cv, p_cr, p_dv, p_dr, p_rv, p_rr, p_rst;
        logic [11:0] p_cmd;
        logic [8:0]  p_dat;
        logic [9:0]  p_rsp;
        p_cv = 0; p_cr = 0; p_dv = 0; p_dr = 0; p_rv = 0; p_rr = 0; p_rst = 1;
        p_cmd = '0; p_dat = '0; p_rsp = '0;
        forever begin
            @(negedge clk);
            if (req_valid && cur_req_ready) acc_cyc = cyc + 1;
            if (cur_cmd_valid && cmd_ready) act_cmd.push_back(cur_cmd);
            if (cur_tvalid && mdata_tready) act_dat.push_back(cur_dat);
            if (cur_s_tready && s_tvalid) s_hs++;
            if (cur_rsp_valid && rsp_ready) begin
                act_rsp.push_back(cur_rsp);
                rsp_cyc    = cyc;
                rsp_cvalid = cur_cmd_valid;
            end
            if (!rst && !p_rst && !cur_tmo) begin
                if (p_cv && !p_cr) check("cmd_stable", {cur_cmd_valid, cur_cmd}, {1'b1, p_cmd});
                if (p_dv && !p_dr) check("data_stable", {cur_tvalid, cur_dat}, {1'b1, p_dat});
            end
            if (!rst && !p_rst && p_rv && !p_rr)
                check("rsp_stable", {cur_rsp_valid, cur_rsp}, {1'b1, p_rsp});
            p_cv = cur_cmd_valid; p_cr = cmd_ready; p_cmd = cur_cmd;
            p_dv = cur_tvalid;    p_dr = mdata_tready; p_dat = cur_dat;
            p_rv = cur_rsp_valid; p_rr = rsp_ready;  p_rsp = cur_rsp;
            p_rst = rst;
        end
    end

    task automatic do_txn(input bit rd, input logic [6:0] dev, input logic [15:0] ra,
                          input logic [7:0] wd, input logic [7:0] sb, input bit pulse,
                          input bit mid_rst, input bit tmo);
        int          n;
        int          nb;
        int          exp_lat;
        logic [11:0] exp_cmd[$];
        logic [8:0]  exp_dat[$];
        logic [9:0]  exp_rsp;
        nb = sel + 1;
        if (!tmo) begin
            exp_cmd.push_back({dev, 1'b1, 1'b0, 1'b0, 1'b1, !rd});
            if (rd) exp_cmd.push_back({dev, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
            for (int i = 0; i < nb; i++)
                exp_dat.push_back({rd && (i == nb - 1), 8'((ra >> (8 * (nb - 1 - i))) & 16'hFF)});
            if (!rd) exp_dat.push_back({1'b1, wd});
        end
        exp_rsp = {(rd && !tmo) ? sb : 8'h00, pulse, tmo};
        exp_lat = tmo ? c_tmo + 1 : 2 * (nb + 2 + int'(rd));

        act_cmd.delete(); act_dat.delete(); act_rsp.delete(); s_hs = 0;
        hold_cmd = tmo;
        @(posedge clk); #1;
        req_dev_addr = dev; req_reg_addr = ra; req_wdata = wd; req_read = rd;
        s_tdata = sb; req_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!cur_req_ready && n < 100);
        check("accept", cur_req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;

        if (pulse) begin
            n = 0;
            while (act_cmd.size() == 0 && n < 500) begin @(negedge clk); #1; n++; end
            @(posedge clk); #1; missed_ack = 1'b1;
            @(posedge clk); #1; missed_ack = 1'b0;
        end

        if (mid_rst) begin
            n = 0;
            while (act_dat.size() < nb && n < 500) begin @(negedge clk); #1; n++; end
            @(posedge clk); #1; rst = 1'b1;
            @(posedge clk); #1; rst = 1'b0;
            @(negedge clk);
            check("rst_outs_a", out_a, 0);
            check("rst_outs_b", out_b, 0);
            repeat (20) @(negedge clk);
            check("rst_no_rsp", act_rsp.size(), 0);
            check("rst_no_wdata", act_dat.size(), nb);
            check("rst_ready", cur_req_ready, 1);
            return;
        end

        n = 0;
        while (act_rsp.size() == 0 && n < 1000) begin @(negedge clk); #1; n++; end
        hold_cmd = 1'b0;
        check("cmd_count", act_cmd.size(), exp_cmd.size());
        foreach (exp_cmd[i]) if (i < act_cmd.size()) check("cmd_beat", act_cmd[i], exp_cmd[i]);
        check("data_count", act_dat.size(), exp_dat.size());
        foreach (exp_dat[i]) if (i < act_dat.size()) check("data_beat", act_dat[i], exp_dat[i]);
        check("rsp_count", act_rsp.size(), 1);
        if (act_rsp.size() > 0) check("rsp_fields", act_rsp[0], exp_rsp);
        check("rd_beats", s_hs, (rd && !tmo) ? 1 : 0);
        if (!bp) check("latency", rsp_cyc - acc_cyc, exp_lat);
        if (tmo) check("tmo_cmd_valid", rsp_cvalid, 0);
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs_a", out_a, 0);
        check("reset_outs_b", out_b, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("ready_in_rst_edge", cur_req_ready, 0);
        @(negedge clk);
        check("ready_after_rst", cur_req_ready, 1);

        sel = 0;
        do_txn(1'b0, 7'h50, 16'h0012, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
        do_txn(1'b1, 7'h68, 16'h003B, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0);
        sel = 1;
        do_txn(1'b0, 7'h22, 16'hBEEF, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
        do_txn(1'b1, 7'h11, 16'h1234, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0);
        sel = 0;
        do_txn(1'b0, 7'h50, 16'h0040, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0);
        do_txn(1'b0, 7'h50, 16'h0041, 8'h78, 8'h00, 1'b0, 1'b0, 1'b0);

        bp = 1'b1;
        for (int t = 0; t < 24; t++) begin
            sel = $urandom_range(0, 1);
            do_txn(1'($urandom_range(0, 1)), 7'($urandom), 16'($urandom), 8'($urandom),
                   8'($urandom), $urandom_range(0, 2) == 0, 1'b0, 1'b0);
        end

        sel = 1;
        do_txn(1'b0, 7'h3A, 16'hCAFE, 8'h99, 8'h00, 1'b0, 1'b1, 1'b0);
        do_txn(1'b0, 7'h3A, 16'hCAFE, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0);
        do_txn(1'b1, 7'h3A, 16'h0102, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0);

`ifdef I2C_REG_TIMEOUT_EN
        bp = 1'b0;
        sel = 0;
        do_txn(1'b0, 7'h50, 16'h0012, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1);
        do_txn(1'b1, 7'h68, 16'h003B, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
